cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
- REQ-001: Parameter NUM_FU, 4, number of functional-unit writeback requesters (2..8).
- REQ-002: clock  input  1  system clock; all state updates on the rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: squash  input  1  flush of all in-flight results (branch mispredict).
- REQ-005: fu_valid  input  NUM_FU  per-FU result-valid request.
- REQ-006: fu_rob_tag  input  NUM_FU x `ROB_TAG_LEN  per-FU ROB tag of the result.
- REQ-007: fu_rd  input  NUM_FU x 5  per-FU architectural destination register.
- REQ-008: fu_value  input  NUM_FU x 32  per-FU result value.
- REQ-009: fu_ready  output  NUM_FU  per-FU acceptance; a transfer occurs when fu_valid[i] && fu_ready[i] at a rising edge.
- REQ-010: cdb_valid  output  1  registered broadcast valid; drives valid_wb of the map table and ROB.
- REQ-011: cdb_rob_tag  output  `ROB_TAG_LEN  broadcast ROB tag (rob_entry_wb).
- REQ-012: cdb_rd  output  5  broadcast destination register (rd_wb).
- REQ-013: cdb_value  output  32  broadcast result value.
- REQ-014: cdb_grant  output  NUM_FU  one-hot index of the FU whose result is on the CDB; all zeros when cdb_valid=0.

Function
- REQ-015: One holding slot per FU (valid bit + tag/rd/value); a transfer loads the slot at the edge.
- REQ-016: fu_ready[i] = !slot_valid[i] || win[i]; derived only from registered state, never from fu_valid.
- REQ-017: Every cycle, exactly one winner is selected among the valid slots; none when no slot is valid.
- REQ-018: At the edge, the winner's payload is registered into cdb_* with cdb_valid=1 and cdb_grant=onehot(winner), and the winner's slot is cleared unless it is reloaded at the same edge.
- REQ-019: Latency: a result accepted at edge E0 appears on the CDB no earlier than the cycle following edge E1 (2-cycle minimum).
- REQ-020: cdb_valid is a one-cycle pulse per result; each accepted result is broadcast exactly once and never duplicated.
- REQ-021: Simultaneous win and new accept on the same FU reloads the slot with no bubble, so a lone FU sustains 1 result/cycle.
- REQ-022: Results with fu_rd == 0 are broadcast unchanged; rd filtering is the consumer's job.
- REQ-023: Outputs hold their last payload values when cdb_valid=0 except cdb_grant, which is zero.
- REQ-024: On squash=1 at an edge, all slots are cleared, cdb_valid/cdb_grant go to 0, and inputs presented at that edge are dropped; fu_ready is all ones the following cycle; the arbitration pointer is unchanged.

Reset
- REQ-025: Reset takes priority over squash and any transfer; fu_valid is ignored during reset.
- REQ-026: After reset: all slots invalid, cdb_valid=0, cdb_rob_tag=0, cdb_rd=0, cdb_value=0, cdb_grant=0, round-robin pointer=0, fu_ready all ones.
- REQ-027: Reset asserted mid-operation discards all pending results; no pre-reset result is broadcast afterward.

Configuration
- REQ-028: With macro CDB_ROUND_ROBIN_EN defined, the winner is the first valid slot searched upward from rr_ptr, wrapping modulo NUM_FU.
- REQ-029: With CDB_ROUND_ROBIN_EN defined, after a grant to FU i, rr_ptr becomes (i+1) mod NUM_FU; rr_ptr is unchanged in cycles with no grant.
- REQ-030: Without CDB_ROUND_ROBIN_EN, the winner is the lowest-index valid slot (fixed priority) and no pointer state exists.

Verification
- REQ-031: Reset, then FU1 presents tag=5, rd=3, value=0xDEAD for one cycle -> the cycle after next shows cdb_valid=1, tag 5, rd 3, 0xDEAD, cdb_grant=0010 for one cycle only.
- REQ-032: All four FUs held valid with fresh payloads every accept -> RR build grants 0,1,2,3,0,1,... every cycle; fixed-priority build grants FU0 every cycle and fu_ready[3] stays 0.
- REQ-033: FU2 alone is valid for three consecutive cycles with tags 1,2,3 -> CDB shows tags 1,2,3 on consecutive cycles and fu_ready[2] stays 1.
- REQ-034: Three slots pending, squash pulsed one cycle -> next cycle cdb_valid=0, fu_ready=1111, and none of the three tags ever appears.
- REQ-035: RR build: grant FU2 (rr_ptr=3), then FU0 and FU3 pending -> FU3 is broadcast, then FU0 (wrap-around).
- REQ-036: Slots full, reset high for one cycle mid-stream -> all outputs are at their reset values and no stale result is broadcast afterward.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: FU writeback requests in, single broadcast result out.
// Tag width comes from ROB_TAG_LEN when the includer defines it.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4
);
  logic [NUM_FU-1:0]                       fu_valid;
  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0]     fu_rob_tag;
  logic [NUM_FU-1:0][4:0]                  fu_rd;
  logic [NUM_FU-1:0][31:0]                 fu_value;
  logic [NUM_FU-1:0]                       fu_ready;
  logic                                    cdb_valid;
  logic [`ROB_TAG_LEN-1:0]                 cdb_rob_tag;
  logic [4:0]                              cdb_rd;
  logic [31:0]                             cdb_value;
  logic [NUM_FU-1:0]                       cdb_grant;

  modport master (
    output fu_valid, fu_rob_tag, fu_rd, fu_value,
    input  fu_ready, cdb_valid, cdb_rob_tag, cdb_rd, cdb_value, cdb_grant
  );

  modport slave (
    input  fu_valid, fu_rob_tag, fu_rd, fu_value,
    output fu_ready, cdb_valid, cdb_rob_tag, cdb_rd, cdb_value, cdb_grant
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, one registered broadcast per cycle.
// Define CDB_ROUND_ROBIN_EN for round-robin selection; default is fixed lowest-index priority.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]                   slot_valid;
  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0] slot_tag;
  logic [NUM_FU-1:0][4:0]              slot_rd;
  logic [NUM_FU-1:0][31:0]             slot_value;
  logic [NUM_FU-1:0]                   win;
  logic [NUM_FU-1:0]                   ready;
  logic [PTR_W-1:0]                    win_idx;
  logic                                found;

`ifdef CDB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W:0]   cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_FU))
        cand = cand - (PTR_W+1)'(NUM_FU);
      if (!found && slot_valid[cand[PTR_W-1:0]]) begin
        found                  = 1'b1;
        win[cand[PTR_W-1:0]]   = 1'b1;
        win_idx                = cand[PTR_W-1:0];
      end
    end
  end
`else
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (!found && slot_valid[k]) begin
        found   = 1'b1;
        win[k]  = 1'b1;
        win_idx = PTR_W'(k);
      end
    end
  end
`endif

  // A slot being broadcast this cycle can take a new result at the same edge.
  always_comb begin
    ready        = ~slot_valid | win;
    bus.fu_ready = ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid      <= '0;
      slot_tag        <= '0;
      slot_rd         <= '0;
      slot_value      <= '0;
      bus.cdb_valid   <= 1'b0;
      bus.cdb_rob_tag <= '0;
      bus.cdb_rd      <= '0;
      bus.cdb_value   <= '0;
      bus.cdb_grant   <= '0;
`ifdef CDB_ROUND_ROBIN_EN
      rr_ptr          <= '0;
`endif
    end else if (squash) begin
      slot_valid    <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_grant <= '0;
    end else begin
      bus.cdb_valid <= found;
      bus.cdb_grant <= win;
      if (found) begin
        bus.cdb_rob_tag <= slot_tag[win_idx];
        bus.cdb_rd      <= slot_rd[win_idx];
        bus.cdb_value   <= slot_value[win_idx];
      end
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (bus.fu_valid[i] && ready[i]) begin
          slot_valid[i] <= 1'b1;
          slot_tag[i]   <= bus.fu_rob_tag[i];
          slot_rd[i]    <= bus.fu_rd[i];
          slot_value[i] <= bus.fu_value[i];
        end else if (win[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
`ifdef CDB_ROUND_ROBIN_EN
      if (found)
        rr_ptr <= (win_idx == PTR_W'(NUM_FU-1)) ? '0 : win_idx + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus hand-written multi-cycle sequences.
// Expectations cover both the fixed-priority and CDB_ROUND_ROBIN_EN builds.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = `ROB_TAG_LEN;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_FU(N)) bus ();
  cdb_arbiter #(.NUM_FU(N)) dut (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .bus   (bus)
  );

  typedef struct {
    logic                 rst;
    logic                 sq;
    logic [N-1:0]         v;
    logic [N-1:0][TW-1:0] tag;
    logic [4:0]           rd;
    logic [31:0]          val;
    logic                 ev;
    logic [N-1:0]         eg;
    logic [TW-1:0]        et;
    logic [4:0]           erd;
    logic [31:0]          eval;
    logic [N-1:0]         er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic sq, input logic [3:0] v,
                     input int t0, input int t1, input int t2, input int t3,
                     input int rd, input logic [31:0] val,
                     input logic ev, input logic [3:0] eg, input int et,
                     input int erd, input logic [31:0] eval, input logic [3:0] er);
    vec_t r;
    r.rst = rst; r.sq = sq; r.v = v;
    r.tag[0] = TW'(t0); r.tag[1] = TW'(t1); r.tag[2] = TW'(t2); r.tag[3] = TW'(t3);
    r.rd = 5'(rd); r.val = val;
    r.ev = ev; r.eg = eg; r.et = TW'(et); r.erd = 5'(erd); r.eval = eval; r.er = er;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_all(input logic [3:0] v, input int base, input int rd, input logic [31:0] val);
    bus.fu_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.fu_rob_tag[i] = TW'(base + i);
      bus.fu_rd[i]      = 5'(rd);
      bus.fu_value[i]   = val;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; squash = 1'b0;
    drive_all(4'b0000, 0, 0, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ready_sq;
`ifdef CDB_ROUND_ROBIN_EN
    ready_sq = 4'b1100;
`else
    ready_sq = 4'b0101;
`endif
    //  rst sq  v        t0  t1  t2  t3  rd  val         ev  eg       et erd eval        er
    add(1, 0, 4'b1111,  1,  2,  3,  4,  9, 32'h55,      0, 4'b0000,  0, 0, 32'h0,      4'b1111);
    add(1, 0, 4'b0000,  0,  0,  0,  0,  0, 32'h0,       0, 4'b0000,  0, 0, 32'h0,      4'b1111);
    add(0, 0, 4'b0010,  0,  5,  0,  0,  3, 32'hDEAD,    0, 4'b0000,  0, 0, 32'h0,      4'b1111);
    add(0, 0, 4'b0000,  0,  0,  0,  0,  0, 32'h0,       1, 4'b0010,  5, 3, 32'hDEAD,   4'b1111);
    add(0, 0, 4'b0000,  0,  0,  0,  0,  0, 32'h0,       0, 4'b0000,  5, 3, 32'hDEAD,   4'b1111);
    add(0, 0, 4'b0100,  0,  0,  1,  0,  7, 32'h101,     0, 4'b0000,  5, 3, 32'hDEAD,   4'b1111);
    add(0, 0, 4'b0100,  0,  0,  2,  0,  7, 32'h102,     1, 4'b0100,  1, 7, 32'h101,    4'b1111);
    add(0, 0, 4'b0100,  0,  0,  3,  0,  7, 32'h103,     1, 4'b0100,  2, 7, 32'h102,    4'b1111);
    add(0, 0, 4'b0000,  0,  0,  0,  0,  0, 32'h0,       1, 4'b0100,  3, 7, 32'h103,    4'b1111);
    add(0, 0, 4'b0000,  0,  0,  0,  0,  0, 32'h0,       0, 4'b0000,  3, 7, 32'h103,    4'b1111);
    add(0, 0, 4'b1011, 10, 11,  0, 13,  1, 32'hBAD,     0, 4'b0000,  3, 7, 32'h103,    ready_sq);
    add(0, 1, 4'b1111, 20, 21, 22, 23,  2, 32'hEEE,     0, 4'b0000,  3, 7, 32'h103,    4'b1111);
    add(0, 0, 4'b0000,  0,  0,  0,  0,  0, 32'h0,       0, 4'b0000,  3, 7, 32'h103,    4'b1111);
    add(0, 0, 4'b0000,  0,  0,  0,  0,  0, 32'h0,       0, 4'b0000,  3, 7, 32'h103,    4'b1111);

    for (int r = 0; r < vecs.size(); r++) begin
      reset = vecs[r].rst; squash = vecs[r].sq; bus.fu_valid = vecs[r].v;
      for (int i = 0; i < N; i++) begin
        bus.fu_rob_tag[i] = vecs[r].tag[i];
        bus.fu_rd[i]      = vecs[r].rd;
        bus.fu_value[i]   = vecs[r].val;
      end
      tick();
      chk($sformatf("row%0d cdb_valid", r), 32'(bus.cdb_valid),   32'(vecs[r].ev));
      chk($sformatf("row%0d cdb_grant", r), 32'(bus.cdb_grant),   32'(vecs[r].eg));
      chk($sformatf("row%0d cdb_tag", r),   32'(bus.cdb_rob_tag), 32'(vecs[r].et));
      chk($sformatf("row%0d cdb_rd", r),    32'(bus.cdb_rd),      32'(vecs[r].erd));
      chk($sformatf("row%0d cdb_value", r), bus.cdb_value,        vecs[r].eval);
      chk($sformatf("row%0d fu_ready", r),  32'(bus.fu_ready),    32'(vecs[r].er));
    end
    squash = 1'b0;

    // All four FUs stay valid with fresh payloads (tag = 4*cycle + fu).
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive_all(4'b1111, 4 * c, 1, 32'(c));
      tick();
      if (c == 0) begin
        chk("sat first cdb_valid", 32'(bus.cdb_valid), 32'd0);
      end else begin
        int g, src;
`ifdef CDB_ROUND_ROBIN_EN
        g   = (c - 1) % 4;
        src = (c <= 4) ? 0 : c - 4;
`else
        g   = 0;
        src = c - 1;
        chk($sformatf("sat c%0d fu_ready3", c), 32'(bus.fu_ready[3]), 32'd0);
`endif
        chk($sformatf("sat c%0d cdb_valid", c), 32'(bus.cdb_valid),   32'd1);
        chk($sformatf("sat c%0d cdb_grant", c), 32'(bus.cdb_grant),   32'(1 << g));
        chk($sformatf("sat c%0d cdb_tag", c),   32'(bus.cdb_rob_tag), 32'(4 * src + g));
      end
    end

    // Pointer wrap: FU2 granted first, then FU0 and FU3 pending together.
    do_reset();
    bus.fu_valid = 4'b0100; bus.fu_rob_tag[2] = TW'(40);
    tick();
    chk("wrap e0 cdb_valid", 32'(bus.cdb_valid), 32'd0);
    bus.fu_valid = 4'b1001; bus.fu_rob_tag[0] = TW'(41); bus.fu_rob_tag[3] = TW'(43);
    tick();
    chk("wrap e1 cdb_grant", 32'(bus.cdb_grant),   32'b0100);
    chk("wrap e1 cdb_tag",   32'(bus.cdb_rob_tag), 32'd40);
    bus.fu_valid = 4'b0000;
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    chk("wrap e2 cdb_grant", 32'(bus.cdb_grant),   32'b1000);
    chk("wrap e2 cdb_tag",   32'(bus.cdb_rob_tag), 32'd43);
    tick();
    chk("wrap e3 cdb_grant", 32'(bus.cdb_grant),   32'b0001);
    chk("wrap e3 cdb_tag",   32'(bus.cdb_rob_tag), 32'd41);
`else
    chk("wrap e2 cdb_grant", 32'(bus.cdb_grant),   32'b0001);
    chk("wrap e2 cdb_tag",   32'(bus.cdb_rob_tag), 32'd41);
    tick();
    chk("wrap e3 cdb_grant", 32'(bus.cdb_grant),   32'b1000);
    chk("wrap e3 cdb_tag",   32'(bus.cdb_rob_tag), 32'd43);
`endif
    tick();
    chk("wrap e4 cdb_valid", 32'(bus.cdb_valid), 32'd0);

    // Result with rd=0 passes through untouched.
    bus.fu_valid = 4'b0010; bus.fu_rob_tag[1] = TW'(7);
    bus.fu_rd[1] = 5'd0; bus.fu_value[1] = 32'h12345678;
    tick();
    bus.fu_valid = 4'b0000;
    tick();
    chk("rd0 cdb_valid", 32'(bus.cdb_valid),   32'd1);
    chk("rd0 cdb_grant", 32'(bus.cdb_grant),   32'b0010);
    chk("rd0 cdb_rd",    32'(bus.cdb_rd),      32'd0);
    chk("rd0 cdb_value", bus.cdb_value,        32'h12345678);

    // Reset mid-stream with slots full: nothing pending may survive.
    do_reset();
    drive_all(4'b1111, 50, 4, 32'h777);
    tick();
    bus.fu_valid = 4'b0000;
    tick();
    chk("rst pre cdb_grant", 32'(bus.cdb_grant),   32'b0001);
    chk("rst pre cdb_tag",   32'(bus.cdb_rob_tag), 32'd50);
    reset = 1'b1;
    drive_all(4'b1111, 60, 5, 32'h888);
    tick();
    reset = 1'b0;
    drive_all(4'b0000, 0, 0, 32'h0);
    chk("rst cdb_valid", 32'(bus.cdb_valid),   32'd0);
    chk("rst cdb_grant", 32'(bus.cdb_grant),   32'd0);
    chk("rst cdb_tag",   32'(bus.cdb_rob_tag), 32'd0);
    chk("rst cdb_rd",    32'(bus.cdb_rd),      32'd0);
    chk("rst cdb_value", bus.cdb_value,        32'd0);
    chk("rst fu_ready",  32'(bus.fu_ready),    32'b1111);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("post rst c%0d cdb_valid", c), 32'(bus.cdb_valid),   32'd0);
      chk($sformatf("post rst c%0d cdb_tag", c),   32'(bus.cdb_rob_tag), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
